// File: rtl/mod_sub_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_sub_datapath_if
// Purpose  : Control/status bundle between the mod/div control FSM and its
//            repeated-subtraction datapath.
// Revision : 1.0
// ============================================================================
interface mod_sub_datapath_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             we;
  logic             x;
  logic [WIDTH-1:0] temp;
  logic [WIDTH-1:0] quotient;
  logic             dbz;

  modport master (
    output start, a, b, s, we,
    input  x, temp, quotient, dbz
  );

  modport slave (
    input  start, a, b, s, we,
    output x, temp, quotient, dbz
  );
endinterface
`default_nettype wire

// File: rtl/mod_sub_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mod_sub_datapath
// Purpose  : Operand, remainder and quotient registers for the repeated-
//            subtraction modulus/divide unit; sequenced by an external FSM.
// Revision : 1.0
// ============================================================================
module mod_sub_datapath #(
  parameter int WIDTH = 32
) (
  input  wire logic        CLK,
  input  wire logic        reset,
  mod_sub_datapath_if.slave bus
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_q;
  logic             w_dbz;
  logic             w_lt;

  assign w_dbz = (r_b == '0);
  assign w_lt  = (r_t < r_b);

  // A subtract only fires while it cannot underflow, so the remainder and
  // quotient self-freeze once the FSM has seen x.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_t <= '0;
      r_q <= '0;
    end else begin
      if (bus.start) begin
        r_a <= bus.a;
        r_b <= bus.b;
      end
      if (bus.we) begin
        if (!bus.s) begin
          r_t <= r_a;
          r_q <= '0;
        end else if (!w_dbz && !w_lt) begin
          r_t <= r_t - r_b;
          r_q <= r_q + C_ONE;
        end
      end
    end
  end

  assign bus.x        = w_dbz | w_lt;
  assign bus.dbz      = w_dbz;
  assign bus.temp     = r_t;
  assign bus.quotient = r_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_sub_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_sub_datapath
// Purpose  : Directed self-checking bench for mod_sub_datapath.
// Revision : 1.0
// ============================================================================
module tb_mod_sub_datapath;

  localparam int WIDTH = 32;

  logic CLK;
  logic reset;
  int   checks;
  int   failures;

  mod_sub_datapath_if #(.WIDTH(WIDTH)) bus ();

  mod_sub_datapath #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [WIDTH-1:0] t,
                           input logic [WIDTH-1:0] q, input logic xv);
    chk({tag, ".temp"}, bus.temp, t);
    chk({tag, ".quot"}, bus.quotient, q);
    chk({tag, ".x"}, {{(WIDTH-1){1'b0}}, bus.x}, {{(WIDTH-1){1'b0}}, xv});
  endtask

  task automatic drive(input logic st, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic sv,
                       input logic wev);
    bus.start = st;
    bus.a     = av;
    bus.b     = bv;
    bus.s     = sv;
    bus.we    = wev;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic capture(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    drive(1'b1, av, bv, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Power-up reset, observed before any clock edge
    #2;
    chk_state("rst", 32'd0, 32'd0, 1'b1);
    chk("rst.dbz", {31'd0, bus.dbz}, 32'd1);
    #6;
    reset = 1'b0;

    // 17 / 5
    capture(32'd17, 32'd5);
    chk_state("l17", 32'd17, 32'd0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick(); chk_state("s1", 32'd12, 32'd1, 1'b0);
    tick(); chk_state("s2", 32'd7,  32'd2, 1'b0);
    tick(); chk_state("s3", 32'd2,  32'd3, 1'b1);
    tick(); chk_state("s4", 32'd2,  32'd3, 1'b1);
    tick(); chk_state("s5", 32'd2,  32'd3, 1'b1);

    // Hold with we=0 at temp=12
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick(); chk_state("pre_hold", 32'd12, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, i[0], 1'b0);
      tick();
      chk_state("hold", 32'd12, 32'd1, 1'b0);
    end

    // New operands captured on the same edge as a subtract on 17/5
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick(); chk_state("reload", 32'd17, 32'd0, 1'b0);
    drive(1'b1, 32'd100, 32'd10, 1'b1, 1'b1);
    tick(); chk_state("conc", 32'd12, 32'd1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick(); chk_state("l100", 32'd100, 32'd0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick(); chk_state("s100", 32'd90, 32'd1, 1'b0);

    // Exact multiple 15 / 5
    capture(32'd15, 32'd5);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk_state("ex3", 32'd0, 32'd3, 1'b1);
    tick(); chk_state("ex4", 32'd0, 32'd3, 1'b1);

    // Dividend below divisor 3 / 7
    capture(32'd3, 32'd7);
    chk_state("lt_load", 32'd3, 32'd0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick(); chk_state("lt_sub", 32'd3, 32'd0, 1'b1);

    // Divide by zero 9 / 0
    capture(32'd9, 32'd0);
    chk("dbz.flag", {31'd0, bus.dbz}, 32'd1);
    chk_state("dbz_load", 32'd9, 32'd0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick(); tick();
    chk_state("dbz_sub", 32'd9, 32'd0, 1'b1);

    // Reset between edges mid-operation
    capture(32'd17, 32'd5);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick(); chk_state("pre_rst", 32'd12, 32'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_state("arst", 32'd0, 32'd0, 1'b1);
    chk("arst.dbz", {31'd0, bus.dbz}, 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick(); chk_state("post_rst", 32'd0, 32'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_sub_datapath.md
Name: mod_sub_datapath

Overview:
Datapath for the repeated-subtraction modulus/divide unit.
- Holds the working remainder register, the captured operands and a quotient counter.
- Driven by the control FSM through s (source select) and we (write enable).
- Returns x (termination flag) and temp (current remainder) to the FSM, which presents temp as result.

Parameters:
WIDTH, 32, data width of operands, remainder and quotient

Ports:
CLK  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all registers
start  input  1  capture a and b into the operand registers this cycle
a  input  WIDTH  dividend
b  input  WIDTH  divisor
s  input  1  0 = load remainder from operand A; 1 = subtract step
we  input  1  remainder/quotient register write enable
x  output  1  termination flag to the FSM (combinational from registers)
temp  output  WIDTH  remainder register value
quotient  output  WIDTH  number of successful subtractions
dbz  output  1  divide-by-zero flag (combinational: B_r == 0)

Behaviour:
- Registers: A_r, B_r, T (drives temp), Q (drives quotient). All are WIDTH bits and all are asynchronously cleared by reset.
- Reset values:
  - A_r = B_r = T = Q = 0.
  - dbz = 1, since B_r = 0.
  - x = 1, because of the dbz force.
- Operand capture: on a rising edge with start=1, A_r <= a and B_r <= b. A_r and B_r hold otherwise.
- Remainder/quotient update on a rising edge with we=1:
  - s=0: T <= A_r, Q <= 0.
  - s=1 and dbz=0 and T >= B_r: T <= T - B_r, Q <= Q + 1.
  - s=1 and (T < B_r or dbz=1): T and Q hold. No underflow and no wrap is allowed.
- we=0: T and Q hold regardless of s.
- start together with we=1 in the same cycle: the T/Q update uses the old A_r/B_r (pre-edge values). The new operands take effect from the next cycle.
- x = dbz | (T < B_r), an unsigned compare. It is valid every cycle with zero latency from the register state.
- Latency for a dividend A and divisor B≠0:
  - 1 load cycle (s=0, we=1).
  - Then floor(A/B) subtract cycles with s=1, we=1.
  - x asserts after the last subtract edge.
  - Final state: T = A mod B, Q = floor(A/B).
- A < B: x=1 immediately after the load edge; T = A, Q = 0.
- B = 0: dbz=1 and x=1 continuously. After the load, T = A_r and Q = 0. Subtract steps never modify T or Q.
- Extra subtract cycles after x=1 (FSM still in subtract state or in result state with we=1) must leave T and Q unchanged.
- Reset mid-operation: all registers clear immediately, without waiting for a clock edge. The first edge after deassertion behaves as from power-up.
- No internal state machine. Sequencing is owned entirely by the control FSM; this block only guarantees the register semantics above.

Test Plan:
- Reset asserted asynchronously between edges -> temp=0, quotient=0, dbz=1, x=1 before the next CLK edge.
- start a=17 b=5; one s=0/we=1 edge; then s=1/we=1 edges:
  - After the load: temp=17, Q=0, x=0.
  - Successive edges: temp=12/7/2, Q=1/2/3.
  - x=1 after the third subtract edge.
  - Two more subtract edges: temp stays 2, Q stays 3.
- Exact multiple, a=15 b=5 -> after 3 subtracts temp=0, Q=3, x=1. A 4th subtract edge does not underflow (temp=0).
- a=3 b=7 -> after the load edge, x=1, temp=3, Q=0. A subtract edge holds both.
- a=9 b=0 -> dbz=1, x=1. After the load, temp=9, Q=0. Subtract edges hold temp=9.
- Hold and concurrency:
  - we=0 with s toggling for 4 cycles mid-operation (temp=12) -> temp and Q unchanged.
  - start a=100 b=10 asserted in the same edge as a subtract on 17/5 -> that edge yields temp=12 (old operands).
  - The next load yields temp=100.
